// File: rtl/cpu_mem_arbiter_pkg.sv
// rtl/cpu_mem_arbiter_pkg.sv - state and grant encodings for the fetch/data memory bus arbiter
package cpu_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    MEM_IDLE        = 3'd0,
    MEM_READ_BEGIN  = 3'd1,
    MEM_READ_WAIT   = 3'd2,
    MEM_WRITE_BEGIN = 3'd3,
    MEM_WRITE_WAIT  = 3'd4
  } mem_state_e;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_e;

  // Round-robin pick: on a tie the side that did not win last time goes next.
  function automatic grant_e pick_grant(input logic i_elig, input logic d_elig, input grant_e last);
    if (i_elig && d_elig) begin
      if (last == GRANT_DATA) return GRANT_FETCH;
      return GRANT_DATA;
    end
    if (i_elig) return GRANT_FETCH;
    return GRANT_DATA;
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - round-robin arbiter sharing one memory bus between fetch and load/store
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic                  mem_ready,
  output logic                  busy
);

  mem_state_e            state_q, state_d;
  grant_e                owner_q, owner_d;
  grant_e                last_grant_q, last_grant_d;
  grant_e                grant;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  i_ack_q, i_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic                  busy_q, busy_d;
  logic                  i_elig, d_elig;

  // A requester being acked this cycle is masked so its still-high req is not served twice.
  assign i_elig = i_req && !i_ack_q;
  assign d_elig = d_req && !d_ack_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    grant        = pick_grant(i_elig, d_elig, last_grant_q);

    case (state_q)
      MEM_IDLE: begin
        if (i_elig || d_elig) begin
          owner_d      = grant;
          last_grant_d = grant;
          if (grant == GRANT_DATA) begin
            mem_addr_d = d_addr;
            if (d_we) begin
              mem_wdata_d = d_wdata;
              state_d     = MEM_WRITE_BEGIN;
            end else begin
              state_d = MEM_READ_BEGIN;
            end
          end else begin
            mem_addr_d = i_addr;
            state_d    = MEM_READ_BEGIN;
          end
        end
      end
      MEM_READ_BEGIN:  state_d = MEM_READ_WAIT;
      MEM_WRITE_BEGIN: state_d = MEM_WRITE_WAIT;
      MEM_READ_WAIT: begin
        if (mem_ready) begin
          state_d = MEM_IDLE;
          if (owner_q == GRANT_FETCH) begin
            i_rdata_d = mem_rdata;
            i_ack_d   = 1'b1;
          end else begin
            d_rdata_d = mem_rdata;
            d_ack_d   = 1'b1;
          end
        end
      end
      MEM_WRITE_WAIT: begin
        if (mem_ready) begin
          state_d = MEM_IDLE;
          i_ack_d = (owner_q == GRANT_FETCH);
          d_ack_d = (owner_q == GRANT_DATA);
        end
      end
      default: state_d = MEM_IDLE;
    endcase

    mem_read_d  = (state_d == MEM_READ_BEGIN)  || (state_d == MEM_READ_WAIT);
    mem_write_d = (state_d == MEM_WRITE_BEGIN) || (state_d == MEM_WRITE_WAIT);
    busy_d      = (state_d != MEM_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= MEM_IDLE;
      owner_q      <= GRANT_FETCH;
      last_grant_q <= GRANT_DATA;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      busy_q       <= busy_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - scoreboard bench for cpu_mem_arbiter
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic [15:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ready = 1'b0;
  logic        busy;

  cpu_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic [15:0] rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ready_delay = 0;
  logic ready_force = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] tbl(input logic [15:0] a);
    case (a)
      16'h0040: return 16'h1234;
      16'h0010: return 16'hA001;
      16'h0100: return 16'hCAFE;
      16'h0200: return 16'h0F0F;
      16'h0300: return 16'h7777;
      16'h0050: return 16'h5555;
      default:  return 16'hDEAD;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: ready after ready_delay extra wait cycles, or always when forced.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_read || mem_write) cnt++;
      else cnt = 0;
      mem_ready = ready_force || ((mem_read || mem_write) && cnt >= 2 + ready_delay);
      mem_rdata = tbl(mem_addr);
    end
  end

  // Monitor: pops one expectation per ack.
  initial forever begin
    @(negedge clk);
    if (reset && (i_ack || d_ack)) begin
      chk("ack_exclusive", {31'd0, i_ack & d_ack}, 32'd0);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: got i_ack=%b d_ack=%b, want none", i_ack, d_ack);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_owner", {31'd0, d_ack}, {31'd0, e.is_d});
        chk(e.is_d ? "d_rdata" : "i_rdata", e.is_d ? {16'd0, d_rdata} : {16'd0, i_rdata}, {16'd0, e.rd});
        chk("ack_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  task automatic wait_ack_drop(input logic is_d);
    int t = 0;
    logic done = 1'b0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
      done = is_d ? d_ack : i_ack;
    end
    if (!done) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (is_d) d_req = 1'b0;
    else i_req = 1'b0;
  endtask

  task automatic run_op(input logic is_d, input logic we, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] exp_rd, input int lat,
                        input logic [15:0] chg, output int rd_cnt, output int wr_cnt);
    int t = 0;
    logic done = 1'b0;
    @(posedge clk);
    #1;
    sb.push_back('{is_d: is_d, rd: exp_rd, cyc: cyc + lat});
    if (is_d) begin
      d_addr = a; d_we = we; d_wdata = wd; d_req = 1'b1;
    end else begin
      i_addr = a; i_req = 1'b1;
    end
    rd_cnt = 0;
    wr_cnt = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
      if (mem_read || mem_write) begin
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, a});
        if (we) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, wd});
      end
      rd_cnt += int'(mem_read);
      wr_cnt += int'(mem_write);
      if (t == 2 && chg != 16'd0) begin
        if (is_d) d_addr = chg;
        else i_addr = chg;
      end
      done = is_d ? d_ack : i_ack;
    end
    if (!done) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (is_d) d_req = 1'b0;
    else i_req = 1'b0;
  endtask

  task automatic tie(input logic [15:0] ia, input logic [15:0] da, input logic data_first);
    @(posedge clk);
    #1;
    if (data_first) begin
      sb.push_back('{is_d: 1'b1, rd: tbl(da), cyc: cyc + 3});
      sb.push_back('{is_d: 1'b0, rd: tbl(ia), cyc: cyc + 6});
    end else begin
      sb.push_back('{is_d: 1'b0, rd: tbl(ia), cyc: cyc + 3});
      sb.push_back('{is_d: 1'b1, rd: tbl(da), cyc: cyc + 6});
    end
    i_addr = ia; d_addr = da; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    fork
      wait_ack_drop(1'b0);
      wait_ack_drop(1'b1);
    join
  endtask

  initial begin
    int rc, wc;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_rdata", {i_rdata, d_rdata}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    ready_force = 1'b1;
    run_op(1'b0, 1'b0, 16'h0040, 16'h0, 16'h1234, 3, 16'h0, rc, wc);
    chk("fetch_read_cycles", rc, 2);
    ready_force = 1'b0;

    ready_delay = 3;
    run_op(1'b1, 1'b0, 16'h0010, 16'h0, 16'hA001, 6, 16'h0020, rc, wc);

    ready_delay = 4;
    run_op(1'b1, 1'b1, 16'h8000, 16'hBEEF, 16'hA001, 7, 16'h0, rc, wc);
    chk("store_write_cycles", wc, 6);
    chk("store_read_cycles", rc, 0);
    ready_delay = 0;

    tie(16'h0100, 16'h0200, 1'b0);
    tie(16'h0300, 16'h0040, 1'b0);
    run_op(1'b0, 1'b0, 16'h0050, 16'h0, 16'h5555, 3, 16'h0, rc, wc);
    tie(16'h0200, 16'h0100, 1'b1);

    // Held data request: masked in its ack cycle, regranted one cycle later.
    @(posedge clk);
    #1;
    sb.push_back('{is_d: 1'b1, rd: 16'h0F0F, cyc: cyc + 3});
    sb.push_back('{is_d: 1'b1, rd: 16'h0F0F, cyc: cyc + 7});
    d_addr = 16'h0200; d_we = 1'b0; d_req = 1'b1;
    begin
      int t = 0;
      while (!d_ack && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!d_ack) chk("ack_timeout", 32'd0, 32'd1);
    end
    @(negedge clk);
    chk("held_no_regrant", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("held_regrant", {31'd0, busy}, 32'd1);
    d_req = 1'b0;
    begin
      int t = 0;
      while (!d_ack && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!d_ack) chk("ack_timeout", 32'd0, 32'd1);
    end

    // Reset in the middle of a read wait.
    @(posedge clk);
    #1;
    ready_delay = 5;
    i_addr = 16'h0300; i_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", {30'd0, busy, mem_read}, 32'd3);
    #1 reset = 1'b0;
    #1;
    chk("midrst_strobes", {29'd0, busy, mem_read, mem_write}, 32'd0);
    chk("midrst_rdata", {i_rdata, d_rdata}, 32'd0);
    chk("midrst_mem_addr", {16'd0, mem_addr}, 32'd0);
    i_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    ready_delay = 0;
    repeat (2) @(posedge clk);
    run_op(1'b0, 1'b0, 16'h0050, 16'h0, 16'h5555, 3, 16'h0, rc, wc);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
